// File: rtl/ram_controller.sv
// ram_controller: word-level read/write/write-verify initiator for a ROWS x DATA_W bit-cell RAM array
// Ports: CLK/RST (sync active-high) | REQ, WE, VERIFY, ADDR, WDATA request side, READY/DONE handshake,
//        RDATA/MISMATCH results | SEL (one-hot row), READ (1=read, 0=write), MEM_IN to cells, MEM_OUT from cells
module ram_controller #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 4,
    parameter int ROWS   = 2 ** ADDR_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ,
    input  logic              WE,
    input  logic              VERIFY,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] WDATA,
    output logic              READY,
    output logic              DONE,
    output logic [DATA_W-1:0] RDATA,
    output logic              MISMATCH,
    output logic [ROWS-1:0]   SEL,
    output logic              READ,
    output logic [DATA_W-1:0] MEM_IN,
    input  logic [DATA_W-1:0] MEM_OUT
);
    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, VSETUP, VACCESS} state_t;
    state_t            state_q;
    logic              ready_q, done_q, mism_q, read_q, we_q, vfy_q;
    logic [DATA_W-1:0] rdata_q, memin_q;
    logic [ROWS-1:0]   sel_q;
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            rdata_q <= '0;
            mism_q  <= 1'b0;
            sel_q   <= '0;
            read_q  <= 1'b1;
            memin_q <= '0;
            we_q    <= 1'b0;
            vfy_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (REQ) begin
                    we_q    <= WE;
                    vfy_q   <= WE & VERIFY;
                    sel_q   <= ROWS'(1) << ADDR;
                    read_q  <= ~WE;
                    memin_q <= WDATA;
                    mism_q  <= 1'b0;
                    ready_q <= 1'b0;
                    state_q <= SETUP;
                end
                SETUP: state_q <= ACCESS;
                ACCESS: if (vfy_q) begin
                    // write edge just taken; flip to read on the same row for the read-back
                    read_q  <= 1'b1;
                    state_q <= VSETUP;
                end else begin
                    if (!we_q) rdata_q <= MEM_OUT;
                    sel_q   <= '0;
                    read_q  <= 1'b1;
                    done_q  <= 1'b1;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                VSETUP: state_q <= VACCESS;
                VACCESS: begin
                    // memin_q still holds the latched write data
                    rdata_q <= MEM_OUT;
                    mism_q  <= MEM_OUT != memin_q;
                    sel_q   <= '0;
                    read_q  <= 1'b1;
                    done_q  <= 1'b1;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign READY    = ready_q;
    assign DONE     = done_q;
    assign RDATA    = rdata_q;
    assign MISMATCH = mism_q;
    assign SEL      = sel_q;
    assign READ     = read_q;
    assign MEM_IN   = memin_q;
endmodule

// File: tb/tb_ram_controller.sv
// tb_ram_controller: randomized bench for ram_controller with a bit-cell array model and a word-level reference
module tb_ram_controller;
    localparam int ADDR_W = 2;
    localparam int DATA_W = 4;
    localparam int ROWS   = 4;
    logic              CLK = 1'b0;
    logic              RST, REQ, WE, VERIFY;
    logic [ADDR_W-1:0] ADDR;
    logic [DATA_W-1:0] WDATA, RDATA, MEM_IN, MEM_OUT;
    logic              READY, DONE, MISMATCH, READ;
    logic [ROWS-1:0]   SEL;
    int n_cmp = 0;
    int n_bad = 0;
    logic [DATA_W-1:0] cells [ROWS];
    logic [DATA_W-1:0] ref_mem [ROWS];
    logic [DATA_W-1:0] stuck = '0;
    logic [DATA_W-1:0] mem_out_q;
    logic [DATA_W-1:0] exp_rdata;
    logic              exp_mism;
    logic              load = 1'b0;
    logic              mon = 1'b0;
    always #5 CLK = ~CLK;
    ram_controller #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .WE(WE), .VERIFY(VERIFY), .ADDR(ADDR), .WDATA(WDATA),
        .READY(READY), .DONE(DONE), .RDATA(RDATA), .MISMATCH(MISMATCH), .SEL(SEL), .READ(READ),
        .MEM_IN(MEM_IN), .MEM_OUT(MEM_OUT)
    );
    function automatic logic [DATA_W-1:0] row_of(input logic [ROWS-1:0] s);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int i = 0; i < ROWS; i++) if (s[i]) r |= cells[i];
        return r;
    endfunction
    // array environment: cells write on SEL&!READ edges, row 1 may have stuck-at-0 bits, read data registered
    always @(posedge CLK) begin
        mem_out_q <= row_of(SEL);
        for (int r = 0; r < ROWS; r++)
            if (load) cells[r] <= ref_mem[r];
            else if (SEL[r] && !READ) cells[r] <= MEM_IN & ~((r == 1) ? stuck : '0);
    end
    assign MEM_OUT = mem_out_q;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    always @(negedge CLK) if (mon && !RST) begin
        chk("sel_onehot", 32'($countones(SEL) <= 1), 32'd1);
        if (SEL == '0) chk("read_when_idle", 32'(READ), 32'd1);
    end
    task automatic chk_reset_vals();
        chk("rst_ready", 32'(READY), 32'd1);
        chk("rst_done", 32'(DONE), 32'd0);
        chk("rst_rdata", 32'(RDATA), 32'd0);
        chk("rst_mismatch", 32'(MISMATCH), 32'd0);
        chk("rst_sel", 32'(SEL), 32'd0);
        chk("rst_read", 32'(READ), 32'd1);
        chk("rst_mem_in", 32'(MEM_IN), 32'd0);
    endtask
    task automatic do_op(input logic we, input logic vfy, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] w);
        int lat;
        logic [DATA_W-1:0] stored;
        @(negedge CLK);
        for (int k = 0; k < 10 && !READY; k++) @(negedge CLK);
        chk("ready_before", 32'(READY), 32'd1);
        REQ = 1'b1; WE = we; VERIFY = vfy; ADDR = a; WDATA = w;
        @(posedge CLK); #1;
        REQ = 1'b0;
        chk("accept_ready", 32'(READY), 32'd0);
        chk("accept_done", 32'(DONE), 32'd0);
        chk("accept_mismatch", 32'(MISMATCH), 32'd0);
        chk("accept_sel", 32'(SEL), 32'(1) << a);
        chk("accept_read", 32'(READ), 32'(!we));
        if (we) begin
            stored = w & ~((a == 1) ? stuck : '0);
            ref_mem[a] = stored;
            if (vfy) exp_rdata = stored;
            exp_mism = vfy && (stored != w);
        end else begin
            exp_rdata = ref_mem[a];
            exp_mism = 1'b0;
        end
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge CLK); #1;
            if (DONE) begin
                lat = k;
                break;
            end
            if (k == 1) begin
                chk("hold_sel", 32'(SEL), 32'(1) << a);
                chk("hold_read", 32'(READ), 32'(!we));
            end
            // requests while busy must be ignored
            REQ = 1'($urandom); WE = 1'($urandom); VERIFY = 1'($urandom);
            ADDR = ADDR_W'($urandom); WDATA = DATA_W'($urandom);
        end
        REQ = 1'b0;
        chk("latency", 32'(lat), (we && vfy) ? 32'd4 : 32'd2);
        chk("rdata", 32'(RDATA), 32'(exp_rdata));
        chk("mismatch", 32'(MISMATCH), 32'(exp_mism));
        chk("done_sel", 32'(SEL), 32'd0);
        chk("done_ready", 32'(READY), 32'd1);
        if (we) chk("mem_in", 32'(MEM_IN), 32'(w));
    endtask
    initial begin
        logic [ADDR_W-1:0] hist [20];
        int ndone;
        for (int r = 0; r < ROWS; r++) ref_mem[r] = DATA_W'($urandom);
        exp_rdata = '0;
        RST = 1'b1; load = 1'b1;
        REQ = 1'b1; WE = 1'b0; VERIFY = 1'b0; ADDR = '0; WDATA = '0;
        repeat (3) @(posedge CLK);
        #1 chk_reset_vals();
        @(negedge CLK);
        RST = 1'b0; load = 1'b0; REQ = 1'b0; mon = 1'b1;
        do_op(1'b1, 1'b0, 2'd2, 4'b1010);
        do_op(1'b0, 1'b0, 2'd2, 4'b0000);
        chk("read_1010", 32'(RDATA), 32'hA);
        repeat (3) @(negedge CLK);
        chk("rdata_held", 32'(RDATA), 32'hA);
        stuck = 4'b0001;
        do_op(1'b1, 1'b1, 2'd1, 4'b0111);
        chk("stuck_rdata", 32'(RDATA), 32'h6);
        chk("stuck_mismatch", 32'(MISMATCH), 32'd1);
        stuck = '0;
        do_op(1'b0, 1'b0, 2'd1, 4'b0000);
        chk("read_clears_mismatch", 32'(MISMATCH), 32'd0);
        do_op(1'b1, 1'b0, 2'd0, 4'b0011);
        chk("write_keeps_rdata", 32'(RDATA), 32'h6);
        // REQ held high with alternating ADDR: one accept every 3 cycles
        @(negedge CLK);
        ndone = 0;
        REQ = 1'b1; WE = 1'b0; VERIFY = 1'b0; hist[1] = 2'd0; ADDR = hist[1];
        for (int i = 1; i <= 15; i++) begin
            @(posedge CLK); #1;
            if (DONE) begin
                ndone++;
                if (i >= 3) chk("stream_rdata", 32'(RDATA), 32'(ref_mem[hist[i-2]]));
            end
            @(negedge CLK);
            hist[i+1] = (i % 2 == 0) ? 2'd0 : 2'd2;
            ADDR = hist[i+1];
        end
        REQ = 1'b0;
        chk("stream_accepts", 32'(ndone), 32'd5);
        // reset during VSETUP
        do_op(1'b0, 1'b0, 2'd3, 4'b0000);
        @(negedge CLK);
        REQ = 1'b1; WE = 1'b1; VERIFY = 1'b1; ADDR = 2'd3; WDATA = 4'b0101;
        @(posedge CLK); #1 REQ = 1'b0;
        ref_mem[3] = 4'b0101;
        @(posedge CLK);
        @(posedge CLK);
        @(negedge CLK) RST = 1'b1;
        @(posedge CLK); #1 chk_reset_vals();
        @(negedge CLK) RST = 1'b0;
        @(posedge CLK); #1 chk("abort_no_done", 32'(DONE), 32'd0);
        exp_rdata = '0;
        do_op(1'b0, 1'b0, 2'd3, 4'b0000);
        chk("abort_row_written", 32'(RDATA), 32'h5);
        // row isolation
        do_op(1'b1, 1'b0, 2'd0, 4'b0001);
        do_op(1'b1, 1'b0, 2'd3, 4'b1110);
        do_op(1'b0, 1'b0, 2'd0, 4'b0000);
        chk("iso_row0", 32'(RDATA), 32'h1);
        do_op(1'b0, 1'b0, 2'd3, 4'b0000);
        chk("iso_row3", 32'(RDATA), 32'hE);
        do_op(1'b0, 1'b0, 2'd1, 4'b0000);
        chk("iso_row1", 32'(RDATA), 32'h6);
        for (int n = 0; n < 60; n++) begin
            stuck = (n >= 30) ? 4'b0100 : 4'b0000;
            do_op(1'($urandom), 1'($urandom), ADDR_W'($urandom), DATA_W'($urandom));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
